// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O hub.
//   - default I/O page addresses and key codes
//   - LFSR tap mask and single-step helper
//   - status register bit positions
//   - io_sel_e: which I/O register (if any) the current address selects
package mmio_pkg;

   localparam logic [15:0] STATUS_ADDR_DEF = 16'h00FC;
   localparam logic [15:0] TIMER_ADDR_DEF  = 16'h00FD;
   localparam logic [15:0] RAND_ADDR_DEF   = 16'h00FE;
   localparam logic [15:0] KEY_ADDR_DEF    = 16'h00FF;

   // byte 0 (LSB) belongs to key 0: w, a, s, d
   localparam logic [31:0] KEY_CODES_DEF = {8'h64, 8'h73, 8'h61, 8'h77};

   // x^8 + x^6 + x^5 + x^4 + 1, right-shifting Galois form
   localparam logic [7:0] LFSR_MASK = 8'hB8;

   localparam int ST_NONEMPTY  = 0;
   localparam int ST_OVERFLOW  = 1;
   localparam int ST_COUNT_LSB = 2;
   localparam int ST_COUNT_MSB = 6;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_STATUS,
      SEL_TIMER,
      SEL_RAND,
      SEL_KEY
   } io_sel_e;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? LFSR_MASK : 8'h00);
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding key-event codes.
//   clk, rst        : clock, async active-high reset (empties the FIFO)
//   push, din       : write request and data; accepted when not full, or
//                     when full and a pop is accepted on the same cycle
//   pop, dout       : read request; dout is the current head (show-ahead),
//                     a pop on an empty FIFO is ignored
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a full FIFO still takes a push when the head leaves the same cycle
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // storage needs no reset: pointers and count define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub between the 6502 core, RAM and peripherals.
// One decoded I/O page: status/control, tick timer, LFSR random source,
// and a key-event FIFO fed by per-key synchronisers and debouncers.
//   clk, rst       : fast system clock, async active-high reset
//   cpu_en         : strobe marking the cycle a CPU bus cycle completes
//   address        : CPU address
//   read_write     : 1 = write, 0 = read
//   data_write     : CPU write data
//   mem_data       : RAM read data
//   data_read      : combinational read data back to the CPU
//   mem_we         : RAM write enable, suppressed for I/O addresses
//   keys           : raw asynchronous key levels, active-high
module mmio_hub
   import mmio_pkg::*;
#(
   parameter int                     NUM_KEYS    = 4,
   parameter logic [NUM_KEYS*8-1:0]  KEY_CODES   = KEY_CODES_DEF,
   parameter int                     FIFO_DEPTH  = 4,
   parameter int                     DEBOUNCE    = 16,
   parameter int                     KEY_MODE    = 0,
   parameter logic [7:0]             LFSR_SEED   = 8'hA5,
   parameter int                     TICK_DIV    = 2500,
   parameter logic [15:0]            STATUS_ADDR = STATUS_ADDR_DEF,
   parameter logic [15:0]            TIMER_ADDR  = TIMER_ADDR_DEF,
   parameter logic [15:0]            RAND_ADDR   = RAND_ADDR_DEF,
   parameter logic [15:0]            KEY_ADDR    = KEY_ADDR_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_en,
   input  logic [15:0]          address,
   input  logic                 read_write,
   input  logic [7:0]           data_write,
   input  logic [7:0]           mem_data,
   output logic [7:0]           data_read,
   output logic                 mem_we,
   input  logic [NUM_KEYS-1:0]  keys
);

   localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   // ---------------- decode ----------------
   io_sel_e io_sel;
   logic    io_hit;
   logic    bus_rd;
   logic    bus_wr;

   always_comb begin
      io_sel = SEL_NONE;
      if (address == STATUS_ADDR)     io_sel = SEL_STATUS;
      else if (address == TIMER_ADDR) io_sel = SEL_TIMER;
      else if (address == RAND_ADDR)  io_sel = SEL_RAND;
      else if (address == KEY_ADDR)   io_sel = SEL_KEY;
   end

   assign io_hit = (io_sel != SEL_NONE);
   assign mem_we = read_write & ~io_hit;
   assign bus_rd = cpu_en & ~read_write;
   assign bus_wr = cpu_en & read_write;

   // ---------------- key synchronise / debounce ----------------
   logic [NUM_KEYS-1:0] sync_0;
   logic [NUM_KEYS-1:0] sync_1;
   logic [NUM_KEYS-1:0] level_d;
   logic [NUM_KEYS-1:0] stable;
   logic [DB_W-1:0]     db_cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0] db_done;
   logic [NUM_KEYS-1:0] press;

   // level has held for DEBOUNCE cycles and did not move this cycle
   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         db_done[i] = (db_cnt[i] == DB_LAST) && (sync_1[i] == level_d[i]);
      end
   end

   assign press = db_done & level_d & ~stable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_0  <= '0;
         sync_1  <= '0;
         level_d <= '0;
         stable  <= '0;
         for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
      end else begin
         sync_0  <= keys;
         sync_1  <= sync_0;
         level_d <= sync_1;
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync_1[i] != level_d[i])  db_cnt[i] <= '0;
            else if (db_cnt[i] != DB_LAST) db_cnt[i] <= db_cnt[i] + 1'b1;
            if (db_done[i]) stable[i] <= level_d[i];
         end
      end
   end

   // lowest-index press wins; any additional same-cycle press is lost
   logic [7:0] press_code;
   logic       press_any;
   logic       press_multi;

   always_comb begin
      press_code = 8'h00;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press[i]) press_code = KEY_CODES[i*8 +: 8];
      end
      press_any   = |press;
      press_multi = (press & (press - 1'b1)) != '0;
   end

   // ---------------- key FIFO ----------------
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;
   logic [CNT_W-1:0] fifo_count;

   assign fifo_pop = (KEY_MODE == 1) && bus_rd && (io_sel == SEL_KEY) && !fifo_empty;

   key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_key_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (press_any),
      .pop   (fifo_pop),
      .din   (press_code),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ---------------- overflow / last key ----------------
   logic       overflow;
   logic       ovf_set;
   logic       ovf_clr;
   logic [7:0] last_key;

   assign ovf_set = press_multi | (press_any & fifo_full & ~fifo_pop);
   assign ovf_clr = bus_wr && (io_sel == SEL_STATUS) && data_write[ST_OVERFLOW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         last_key <= 8'h00;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (press_any) last_key <= press_code;
      end
   end

   // ---------------- LFSR ----------------
   logic [7:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (bus_wr && (io_sel == SEL_RAND)) begin
         // all-zero is the LFSR's lock-up state
         lfsr <= (data_write == 8'h00) ? 8'h01 : data_write;
      end else begin
         lfsr <= lfsr_step(lfsr);
      end
   end

   // ---------------- tick timer ----------------
   logic [PS_W-1:0] prescale;
   logic [7:0]      timer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale <= '0;
         timer    <= 8'h00;
      end else if (bus_wr && (io_sel == SEL_TIMER)) begin
         prescale <= '0;
         timer    <= data_write;
      end else if (prescale == PS_LAST) begin
         prescale <= '0;
         timer    <= timer + 8'h01;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   // ---------------- read mux ----------------
   logic [7:0] status;

   always_comb begin
      status = 8'h00;
      status[ST_NONEMPTY] = ~fifo_empty;
      status[ST_OVERFLOW] = overflow;
      status[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count);
   end

   always_comb begin
      case (io_sel)
         SEL_STATUS: data_read = status;
         SEL_TIMER:  data_read = timer;
         SEL_RAND:   data_read = lfsr;
         SEL_KEY:    data_read = (KEY_MODE == 1) ? (fifo_empty ? 8'h00 : fifo_dout) : last_key;
         default:    data_read = mem_data;
      endcase
   end

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub. Two instances share all stimulus:
// dut runs the FIFO key mode, dut_m0 the hold-last-key mode. A reference
// model keeps the key FIFO as a queue and derives timer/LFSR values from
// the cycle count elapsed since their last load.
`timescale 1ns/1ps
module tb_mmio_hub;

   localparam int          TICK_DIV = 2500;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] CODES    = {8'h64, 8'h73, 8'h61, 8'h77};
   localparam logic [15:0] A_STAT   = 16'h00FC;
   localparam logic [15:0] A_TIMER  = 16'h00FD;
   localparam logic [15:0] A_RAND   = 16'h00FE;
   localparam logic [15:0] A_KEY    = 16'h00FF;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_en;
   logic [15:0] address;
   logic        read_write;
   logic [7:0]  data_write;
   logic [7:0]  mem_data;
   logic [7:0]  data_read;
   logic [7:0]  data_read_m0;
   logic        mem_we;
   logic        mem_we_m0;
   logic [3:0]  keys;

   always #5 clk = ~clk;

   mmio_hub #(.KEY_MODE(1), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .address(address),
      .read_write(read_write), .data_write(data_write), .mem_data(mem_data),
      .data_read(data_read), .mem_we(mem_we), .keys(keys)
   );

   mmio_hub #(.KEY_MODE(0), .TICK_DIV(TICK_DIV)) dut_m0 (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .address(address),
      .read_write(read_write), .data_write(data_write), .mem_data(mem_data),
      .data_read(data_read_m0), .mem_we(mem_we_m0), .keys(keys)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model state ----------------
   logic [7:0] q[$];
   bit         ovf;
   logic [7:0] last_key;
   logic [7:0] l_base;
   int         l_cyc;
   logic [7:0] t_base;
   int         t_cyc;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %02h exp %02h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] key_code(input int i);
      logic [31:0] c;
      c = CODES;
      return c[i*8 +: 8];
   endfunction

   // polynomial x^8+x^6+x^5+x^4+1, one step per clock
   function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int k = 0; k < n; k++) r = r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
      return r;
   endfunction

   function automatic logic [7:0] exp_read(input logic [15:0] a, input bit mode1, input logic [7:0] md);
      case (a)
         A_STAT:  return {1'b0, 5'(q.size()), ovf, q.size() != 0};
         A_TIMER: return 8'((int'(t_base) + (cyc - t_cyc) / TICK_DIV) % 256);
         A_RAND:  return lfsr_adv(l_base, cyc - l_cyc);
         A_KEY:   return mode1 ? ((q.size() != 0) ? q[0] : 8'h00) : last_key;
         default: return md;
      endcase
   endfunction

   function automatic void model_press(input logic [7:0] code);
      if (q.size() == DEPTH) ovf = 1'b1;
      else q.push_back(code);
      last_key = code;
   endfunction

   // ---------------- bus tasks (called and returning on a negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_read(input string tag, input logic [15:0] a, output logic [7:0] got);
      logic [7:0] md, e1, e0;
      md = 8'($urandom);
      address = a; read_write = 1'b0; cpu_en = 1'b1;
      mem_data = md; data_write = 8'($urandom);
      #1;
      e1 = exp_read(a, 1'b1, md);
      e0 = exp_read(a, 1'b0, md);
      got = data_read;
      check_val(tag, data_read, e1);
      if (a != A_STAT) check_val({tag, "_m0"}, data_read_m0, e0);
      check_val({tag, "_we"}, {7'b0, mem_we}, 8'h00);
      if (a == A_KEY && q.size() != 0) void'(q.pop_front());
      if (a == A_RAND) begin
         l_base = e1;
         l_cyc  = cyc;
      end
      @(posedge clk);
      @(negedge clk);
      cpu_en = 1'b0;
   endtask

   task automatic bus_write(input string tag, input logic [15:0] a, input logic [7:0] v);
      bit io;
      io = a inside {A_STAT, A_TIMER, A_RAND, A_KEY};
      address = a; read_write = 1'b1; cpu_en = 1'b1;
      data_write = v; mem_data = 8'($urandom);
      #1;
      check_val({tag, "_we"}, {7'b0, mem_we}, io ? 8'h00 : 8'h01);
      check_val({tag, "_we_m0"}, {7'b0, mem_we_m0}, io ? 8'h00 : 8'h01);
      @(posedge clk);
      @(negedge clk);
      cpu_en = 1'b0; read_write = 1'b0;
      case (a)
         A_TIMER: begin t_base = v; t_cyc = cyc; end
         A_RAND:  begin l_base = (v == 8'h00) ? 8'h01 : v; l_cyc = cyc; end
         A_STAT:  if (v[1]) ovf = 1'b0;
         default: ;
      endcase
   endtask

   task automatic press_key(input int i);
      keys[i] = 1'b1;
      idle(40);
      keys[i] = 1'b0;
      idle(40);
      model_press(key_code(i));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      q.delete();
      ovf = 1'b0; last_key = 8'h00;
      l_base = 8'hA5; l_cyc = cyc;
      t_base = 8'h00; t_cyc = cyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  got;
      logic [15:0] io_addrs [4];
      int          lat;
      bit          found;
      io_addrs = '{A_STAT, A_TIMER, A_RAND, A_KEY};

      rst = 1'b1; cpu_en = 1'b0; read_write = 1'b0; address = 16'h0000;
      data_write = 8'h00; mem_data = 8'h00; keys = '0;
      @(negedge clk);
      do_reset();
      idle(30);

      // reset mid-run with pending key events
      press_key(0);
      press_key(1);
      idle(7);
      do_reset();
      idle(3);
      bus_read("rst_rand", A_RAND, got);
      bus_read("rst_status", A_STAT, got);
      check_val("rst_status_c", got, 8'h00);
      bus_read("rst_timer", A_TIMER, got);

      // debounce: short glitch then a real press on key 1
      keys[1] = 1'b1; idle(10);
      keys[1] = 1'b0; idle(10);
      keys[1] = 1'b1; idle(20);
      keys[1] = 1'b0; idle(40);
      model_press(key_code(1));
      bus_read("db_stat1", A_STAT, got);
      bus_read("db_key1", A_KEY, got);
      check_val("db_key1_c", got, 8'h61);
      bus_read("db_key2", A_KEY, got);
      check_val("db_key2_c", got, 8'h00);
      bus_read("db_stat2", A_STAT, got);

      // overflow: five presses into a four-deep FIFO
      press_key(0); press_key(1); press_key(2); press_key(3); press_key(0);
      bus_read("ovf_stat", A_STAT, got);
      check_val("ovf_stat_c", got, 8'h13);
      bus_read("ovf_pop0", A_KEY, got); check_val("ovf_pop0_c", got, 8'h77);
      bus_read("ovf_pop1", A_KEY, got); check_val("ovf_pop1_c", got, 8'h61);
      bus_read("ovf_pop2", A_KEY, got); check_val("ovf_pop2_c", got, 8'h73);
      bus_read("ovf_pop3", A_KEY, got); check_val("ovf_pop3_c", got, 8'h64);
      bus_read("ovf_stat2", A_STAT, got);
      bus_write("ovf_clr", A_STAT, 8'h02);
      bus_read("ovf_stat3", A_STAT, got);
      check_val("ovf_stat3_c", got, 8'h00);

      // simultaneous presses on keys 0 and 3
      keys[0] = 1'b1; keys[3] = 1'b1; idle(40);
      keys[0] = 1'b0; keys[3] = 1'b0; idle(40);
      ovf = 1'b1;
      model_press(key_code(0));
      bus_read("sim_stat", A_STAT, got);
      check_val("sim_stat_c", got, 8'h07);
      bus_read("sim_key", A_KEY, got);
      check_val("sim_key_c", got, 8'h77);
      bus_read("sim_stat2", A_STAT, got);
      bus_write("sim_clr", A_STAT, 8'h02);

      // find how many cycles a press takes to land, so a pop can be aimed at it
      keys[0] = 1'b1;
      found = 1'b0;
      lat = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         address = A_STAT; read_write = 1'b0; cpu_en = 1'b1;
         #1;
         if (data_read[0]) begin
            found = 1'b1;
            lat = k;
         end
         @(posedge clk);
         @(negedge clk);
         cpu_en = 1'b0;
      end
      if (!found) begin
         check_val("press_latency_timeout", 8'h00, 8'h01);
         lat = 20;
      end
      keys[0] = 1'b0; idle(40);
      model_press(key_code(0));
      bus_read("cal_pop", A_KEY, got);
      press_key(1); press_key(2); press_key(3); press_key(0);
      bus_read("full_stat", A_STAT, got);
      check_val("full_stat_c", got, 8'h11);
      keys[1] = 1'b1;
      idle(lat - 1);
      bus_read("pp_pop", A_KEY, got);
      model_press(key_code(1));
      keys[1] = 1'b0; idle(40);
      bus_read("pp_stat", A_STAT, got);
      check_val("pp_stat_c", got, 8'h11);
      for (int k = 0; k < 4; k++) bus_read("pp_drain", A_KEY, got);
      check_val("pp_last_c", got, 8'h61);

      // decode, gating and timer
      bus_write("tmr_wr", A_TIMER, 8'h3C);
      idle(TICK_DIV - 1);
      bus_read("tmr_pre", A_TIMER, got);
      check_val("tmr_pre_c", got, 8'h3C);
      bus_read("tmr_tick", A_TIMER, got);
      check_val("tmr_tick_c", got, 8'h3D);
      bus_write("tmr_ff", A_TIMER, 8'hFF);
      idle(TICK_DIV);
      bus_read("tmr_wrap", A_TIMER, got);
      check_val("tmr_wrap_c", got, 8'h00);
      bus_write("ram_wr", 16'h0200, 8'h5A);
      bus_read("ram_rd", 16'h0200, got);

      // LFSR zero-seed rule and hold-last-key mode
      bus_write("lfsr_z", A_RAND, 8'h00);
      idle(5);
      bus_read("lfsr_z_rd", A_RAND, got);
      press_key(2);
      bus_read("m0_key1", A_KEY, got);
      check_val("m0_key1_c", data_read_m0, 8'h73);
      bus_read("m0_key2", A_KEY, got);
      check_val("m0_key2_c", data_read_m0, 8'h73);

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         logic [15:0] a;
         if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(16'h0100, 16'hFFFF));
         else a = io_addrs[$urandom_range(0, 3)];
         case ($urandom_range(0, 3))
            0: bus_read("rnd_rd", a, got);
            1: bus_write("rnd_wr", a, 8'($urandom));
            2: press_key(int'($urandom_range(0, 3)));
            default: idle(int'($urandom_range(1, 300)));
         endcase
      end
      bus_read("end_stat", A_STAT, got);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
